inst_refill_axi: RTL

INST_REFILL_AXI -- requirements
Module: inst_refill_axi

---
 rtl/inst_refill_axi_pkg.sv | 27 ++
 rtl/inst_refill_axi_line_buf.sv | 29 ++
 rtl/inst_refill_axi.sv | 120 ++++++++++++
 3 files changed

// File: rtl/inst_refill_axi_pkg.sv
// Shared types and AXI constants for the instruction-refill AXI read master.
package inst_refill_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int          AXI_ID_W       = 4;
   localparam logic [3:0]  AXI_ID_DEFAULT = 4'h0;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

   // Physical address: top 3 bits dropped; cached requests are line-aligned.
   function automatic logic [31:0] refill_addr(input logic [31:0] addr,
                                               input logic        uncached,
                                               input int unsigned off_bits);
      logic [31:0] base;
      base = {3'b000, addr[28:0]};
      if (uncached) return base;
      return base & (32'hFFFF_FFFF << off_bits);
   endfunction

endpackage

// File: rtl/inst_refill_axi_line_buf.sv
// Line buffer: LINE_WORDS x 32 registers, one indexed write port, flat read bus.
module inst_line_buf #(
   parameter int LINE_WORDS = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    we,
   input  logic [3:0]              widx,
   input  logic [31:0]             wdata,
   output logic [32*LINE_WORDS-1:0] rdata
);

   logic [31:0] mem_q [LINE_WORDS];

   // Indices past the end of the line (overlong bursts) are dropped.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < LINE_WORDS; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < LINE_WORDS; i++)
            if (we && widx == 4'(i)) mem_q[i] <= wdata;
      end
   end

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rd
      assign rdata[32*g +: 32] = mem_q[g];
   end

endmodule

// File: rtl/inst_refill_axi.sv
// Instruction-cache refill engine: one AXI read (line burst or single beat) per miss.
module inst_refill_axi
   import inst_refill_axi_pkg::*;
#(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] AXI_ID     = AXI_ID_DEFAULT
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     req_valid,
   input  logic [31:0]              req_addr,
   input  logic                     req_uncached,
   output logic                     req_ready,
   output logic                     line_valid,
   output logic [32*LINE_WORDS-1:0] line_data,
   output logic [31:0]              line_addr,
   output logic                     line_err,
   output logic [3:0]               arid,
   output logic [31:0]              araddr,
   output logic [3:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic [1:0]               arlock,
   output logic [3:0]               arcache,
   output logic [2:0]               arprot,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [3:0]               rid,
   input  logic [31:0]              rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready
);

   localparam int unsigned OFF_BITS = $clog2(LINE_WORDS) + 2;
   localparam logic [3:0]  LEN_LINE = 4'(LINE_WORDS - 1);

   state_e      state_q;
   logic [31:0] araddr_q;
   logic        uncached_q;
   logic        killed_q;
   logic        err_q;
   logic [3:0]  cnt_q;
   logic        beat_acc;

   assign beat_acc = rvalid && rready && (rid == AXI_ID);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         araddr_q   <= '0;
         uncached_q <= 1'b0;
         killed_q   <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && !flush) begin
                  state_q    <= ST_AR;
                  araddr_q   <= refill_addr(req_addr, req_uncached, OFF_BITS);
                  uncached_q <= req_uncached;
                  killed_q   <= 1'b0;
                  err_q      <= 1'b0;
                  cnt_q      <= '0;
               end
            end
            // A flush cannot withdraw arvalid; it only suppresses the result.
            ST_AR: begin
               if (flush) killed_q <= 1'b1;
               if (arready) state_q <= ST_R;
            end
            ST_R: begin
               if (flush) killed_q <= 1'b1;
               if (beat_acc) begin
                  cnt_q <= cnt_q + 4'd1;
                  if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
                  if (rlast) begin
                     state_q <= ST_DONE;
                     if (cnt_q != arlen) err_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (flush) killed_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   inst_line_buf #(.LINE_WORDS(LINE_WORDS)) u_line_buf (
      .clk    (clk),
      .resetn (resetn),
      .we     (beat_acc),
      .widx   (cnt_q),
      .wdata  (rdata),
      .rdata  (line_data)
   );

   assign req_ready  = (state_q == ST_IDLE);
   assign arvalid    = (state_q == ST_AR);
   assign rready     = (state_q == ST_R);
   assign line_valid = (state_q == ST_DONE) && !killed_q && !flush;
   assign line_addr  = araddr_q;
   assign line_err   = err_q;

   assign arid    = AXI_ID;
   assign araddr  = araddr_q;
   assign arlen   = uncached_q ? 4'd0 : LEN_LINE;
   assign arsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

endmodule
